parking_slot_sequencer: RTL and testbench
=========================================

Name: parking_slot_sequencer

Overview:
Occupancy controller for the lot. Accepts entry and exit requests from the gate sensors and arbitrates between them for a single shared external 4-bit ripple adder. It drives the adder's operands and commits the sum into the occupancy register. It also reports full/empty status and sequences one grant at a time with a req/ack/deny handshake.

Parameters:
CAPACITY, 15, number of slots; legal range 1..15; full when count == CAPACITY.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
entry_req  input  1  entry gate request; held high until entry_ack or entry_deny is seen
exit_req  input  1  exit gate request; held high until exit_ack or exit_deny is seen
add_sum  input  4  sum from the shared adder
add_cout  input  1  carry-out from the shared adder
add_a  output  4  adder operand a, always equal to count
add_b  output  4  adder operand b
add_cin  output  1  adder carry-in, always 0
count  output  4  current occupancy
full  output  1  combinational, count == CAPACITY
empty  output  1  combinational, count == 0
entry_ack  output  1  one-cycle pulse: entry committed
exit_ack  output  1  one-cycle pulse: exit committed
entry_deny  output  1  one-cycle pulse: entry refused because the lot is full
exit_deny  output  1  one-cycle pulse: exit refused because the lot is empty
err  output  1  sticky adder-consistency error

Behaviour:
- Reset values: count=0, all ack/deny outputs 0, err=0, state=IDLE, last_served=EXIT (entry wins the first tie).
- States: IDLE, ADD_IN, ADD_OUT, DONE, DENY. Exactly one state is active per cycle.
- IDLE grant rules:
  - entry is grantable when entry_req && !full.
  - exit is grantable when exit_req && !empty.
  - Both grantable: serve the side opposite last_served (round-robin), then update last_served.
  - One grantable: serve it (go to ADD_IN or ADD_OUT).
  - None grantable but a request is pending: go to DENY, latching entry_deny_pend = entry_req && full and exit_deny_pend = exit_req && empty.
  - No requests: stay in IDLE.
- A blocked request is never denied while the other side is granted in the same IDLE cycle. It is re-evaluated on the next IDLE cycle.
- Adder operand drive:
  - ADD_IN: add_b = 4'b0001.
  - ADD_OUT: add_b = 4'b1111 (two's-complement -1).
  - All other states: add_b = 0.
  - add_a = count and add_cin = 0 in every state.
- ADD_IN commit: at the end of the cycle, if add_cout == 0, count <= add_sum; otherwise count is held and err <= 1. Then go to DONE.
- ADD_OUT commit: at the end of the cycle, if add_cout == 1, count <= add_sum; otherwise count is held and err <= 1. Then go to DONE.
- DONE: assert the ack for the served side for exactly one cycle, even when err was set. Then go to IDLE.
- DENY: assert the latched deny pulse(s) for exactly one cycle, then go to IDLE.
- Requests are ignored in ADD_*, DONE and DENY.
- Requester contract: the requester drops req on the clock edge where it samples ack/deny high, so the following IDLE cycle sees the request low.
- Latency: req high in IDLE cycle N gives ADD in N+1, count updated at the N+1 edge, ack in N+2, IDLE in N+3. The minimum spacing between commits is 3 cycles.
- count never exceeds CAPACITY and never wraps below 0; full/empty gating guarantees this. err only flags a faulty adder.
- Reset mid-operation (any state): the next edge returns to reset values. A commit in progress is lost and no ack is issued.
- err stays set until reset. The block keeps operating while err is set.

Test Plan:
- Reset, then entry_req held until ack -> add_b=0001 during ADD_IN, count 0->1, entry_ack pulses 2 cycles after the request was sampled, empty falls.
- count=3, entry_req and exit_req raised in the same IDLE cycle after reset -> entry served first (count=4, entry_ack). Exit served next (count=3, exit_ack). A repeated tie serves exit first.
- CAPACITY=4 fill to 4, then entry_req -> full=1, entry_deny single-cycle pulse, count stays 4. Then exit_req -> count=3, full=0.
- From reset, exit_req -> exit_deny pulse, count 0, add_b never 1111.
- Force add_cout=1 during ADD_IN at count=2 -> count stays 2, err=1, entry_ack still pulses. err stays high through later normal commits until reset.
- Assert reset while in ADD_OUT at count=5 -> next cycle count=0, no exit_ack, state IDLE, err=0.

Source files
------------

// File: rtl/parking_slot_sequencer.sv
// Parking lot occupancy controller.
// Arbitrates entry/exit gate requests for one shared external 4-bit adder.
// It commits the adder result into the occupancy count and answers each
// request with a one-cycle ack or deny pulse.
module parking_slot_sequencer #(
  parameter int unsigned CAPACITY = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_deny,
  output logic       exit_deny,
  output logic       err
);

  localparam logic [3:0] CAP = 4'(CAPACITY);

  typedef enum logic [2:0] {IDLE, ADD_IN, ADD_OUT, DONE, DENY} state_t;
  typedef enum logic {SIDE_ENTRY, SIDE_EXIT} side_t;

  state_t state;
  side_t  last_served;
  logic   entry_ok;
  logic   exit_ok;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign add_a   = count;
  assign add_cin = 1'b0;

  // A side is grantable only when the commit cannot overflow or underflow.
  always_comb begin
    entry_ok = entry_req && !full;
    exit_ok  = exit_req && !empty;
  end

  // Adder operand b: +1 while admitting a car, -1 (two's complement) while releasing one.
  always_comb begin
    add_b = '0;
    case (state)
      ADD_IN:  add_b = 4'b0001;
      ADD_OUT: add_b = 4'b1111;
      default: add_b = '0;
    endcase
  end

  // Sequencer: grant/deny in IDLE, commit in ADD_*, pulse ack/deny in DONE/DENY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= SIDE_EXIT;
      count       <= '0;
      err         <= 1'b0;
      entry_ack   <= 1'b0;
      exit_ack    <= 1'b0;
      entry_deny  <= 1'b0;
      exit_deny   <= 1'b0;
    end else begin
      entry_ack  <= 1'b0;
      exit_ack   <= 1'b0;
      entry_deny <= 1'b0;
      exit_deny  <= 1'b0;
      case (state)
        IDLE: begin
          if (entry_ok && exit_ok) begin
            // Round-robin only on a genuine tie; single grants leave the pointer alone.
            if (last_served == SIDE_EXIT) begin
              state       <= ADD_IN;
              last_served <= SIDE_ENTRY;
            end else begin
              state       <= ADD_OUT;
              last_served <= SIDE_EXIT;
            end
          end else if (entry_ok) begin
            state <= ADD_IN;
          end else if (exit_ok) begin
            state <= ADD_OUT;
          end else if (entry_req || exit_req) begin
            // The deny flags are registered here, so they pulse during the DENY cycle.
            state      <= DENY;
            entry_deny <= entry_req && full;
            exit_deny  <= exit_req && empty;
          end
        end
        ADD_IN: begin
          if (!add_cout) count <= add_sum;
          else           err   <= 1'b1;
          entry_ack <= 1'b1;
          state     <= DONE;
        end
        ADD_OUT: begin
          if (add_cout) count <= add_sum;
          else          err   <= 1'b1;
          exit_ack <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        DENY:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_slot_sequencer.sv
// Bench for parking_slot_sequencer: two instances (capacity 15 and 4), each with its own adder.
// Directed vector tables are followed by randomized traffic checked against a transaction-level model.
module tb_parking_slot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst  = 2'b11;
  logic [1:0] ereq = '0;
  logic [1:0] xreq = '0;
  logic [1:0] fc   = '0;

  wire [1:0][3:0] add_sum, add_a, add_b, count;
  wire [1:0] add_cout, add_cin, full, empty, eack, xack, edeny, xdeny, err;

  int cap [2] = '{15, 4};

  // Shared-adder stand-ins; fc forces a bogus carry-out to provoke the consistency check.
  for (genvar g = 0; g < 2; g++) begin : g_add
    wire [4:0] raw = {1'b0, add_a[g]} + {1'b0, add_b[g]} + {4'b0, add_cin[g]};
    assign add_sum[g]  = raw[3:0];
    assign add_cout[g] = fc[g] ? 1'b1 : raw[4];
  end

  parking_slot_sequencer #(.CAPACITY(15)) dut0 (
    .clk(clk), .reset(rst[0]), .entry_req(ereq[0]), .exit_req(xreq[0]),
    .add_sum(add_sum[0]), .add_cout(add_cout[0]), .add_a(add_a[0]), .add_b(add_b[0]),
    .add_cin(add_cin[0]), .count(count[0]), .full(full[0]), .empty(empty[0]),
    .entry_ack(eack[0]), .exit_ack(xack[0]), .entry_deny(edeny[0]), .exit_deny(xdeny[0]),
    .err(err[0]));

  parking_slot_sequencer #(.CAPACITY(4)) dut1 (
    .clk(clk), .reset(rst[1]), .entry_req(ereq[1]), .exit_req(xreq[1]),
    .add_sum(add_sum[1]), .add_cout(add_cout[1]), .add_a(add_a[1]), .add_b(add_b[1]),
    .add_cin(add_cin[1]), .count(count[1]), .full(full[1]), .empty(empty[1]),
    .entry_ack(eack[1]), .exit_ack(xack[1]), .entry_deny(edeny[1]), .exit_deny(xdeny[1]),
    .err(err[1]));

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string what, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d", what, d, act, exp);
    end
  endtask

  task automatic check_outputs(input int d, input int cnt, input int b,
                               input bit ea, input bit xa, input bit ed, input bit xd, input bit er);
    cmp("count", d, 32'(count[d]), cnt);
    cmp("add_a", d, 32'(add_a[d]), cnt);
    cmp("add_b", d, 32'(add_b[d]), b);
    cmp("add_cin", d, 32'(add_cin[d]), 0);
    cmp("full", d, 32'(full[d]), 32'(cnt == cap[d]));
    cmp("empty", d, 32'(empty[d]), 32'(cnt == 0));
    cmp("entry_ack", d, 32'(eack[d]), 32'(ea));
    cmp("exit_ack", d, 32'(xack[d]), 32'(xa));
    cmp("entry_deny", d, 32'(edeny[d]), 32'(ed));
    cmp("exit_deny", d, 32'(xdeny[d]), 32'(xd));
    cmp("err", d, 32'(err[d]), 32'(er));
  endtask

  // One row = inputs for one cycle plus the outputs expected during that cycle.
  typedef struct {
    int d;
    bit rst, e, x, fc, chk;
    int cnt, b;
    bit ea, xa, ed, xd, er;
  } vec_t;
  vec_t tv[$];

  function automatic void row(int d, bit r, bit e, bit x, bit f, bit chk, int cnt, int b,
                              bit ea, bit xa, bit ed, bit xd, bit er);
    vec_t v;
    v = '{d, r, e, x, f, chk, cnt, b, ea, xa, ed, xd, er};
    tv.push_back(v);
  endfunction

  // A lone entry starting from an IDLE cycle with occupancy c.
  function automatic void entry_rows(int d, int c, bit er);
    row(d, 0, 1, 0, 0, 1, c,     0, 0, 0, 0, 0, er);
    row(d, 0, 1, 0, 0, 1, c,     1, 0, 0, 0, 0, er);
    row(d, 0, 1, 0, 0, 1, c + 1, 0, 1, 0, 0, 0, er);
    row(d, 0, 0, 0, 0, 1, c + 1, 0, 0, 0, 0, 0, er);
  endfunction

  function automatic void exit_rows(int d, int c, bit er);
    row(d, 0, 0, 1, 0, 1, c,     0,  0, 0, 0, 0, er);
    row(d, 0, 0, 1, 0, 1, c,     15, 0, 0, 0, 0, er);
    row(d, 0, 0, 1, 0, 1, c - 1, 0,  0, 1, 0, 0, er);
    row(d, 0, 0, 0, 0, 1, c - 1, 0,  0, 0, 0, 0, er);
  endfunction

  // Reference model: a transaction in flight is a countdown (2 = adder cycle, 1 = response cycle).
  int m_cnt [2];
  int m_busy [2];
  bit m_err [2], m_last_entry [2], m_side_entry [2], m_deny [2], m_de [2], m_dx [2];

  task automatic model_step(input int i);
    bit ge, gx;
    if (rst[i]) begin
      m_cnt[i] = 0; m_busy[i] = 0; m_err[i] = 0; m_last_entry[i] = 0;
      m_side_entry[i] = 0; m_deny[i] = 0; m_de[i] = 0; m_dx[i] = 0;
    end else if (m_busy[i] == 0) begin
      ge = ereq[i] && (m_cnt[i] < cap[i]);
      gx = xreq[i] && (m_cnt[i] > 0);
      if (ge && gx) begin
        m_side_entry[i] = !m_last_entry[i];
        m_last_entry[i] = m_side_entry[i];
        m_deny[i] = 0; m_busy[i] = 2;
      end else if (ge || gx) begin
        m_side_entry[i] = ge;
        m_deny[i] = 0; m_busy[i] = 2;
      end else if (ereq[i] || xreq[i]) begin
        m_deny[i] = 1;
        m_de[i] = ereq[i] && (m_cnt[i] == cap[i]);
        m_dx[i] = xreq[i] && (m_cnt[i] == 0);
        m_busy[i] = 1;
      end
    end else if (m_busy[i] == 2) begin
      if (m_side_entry[i]) begin
        if (fc[i]) m_err[i] = 1;
        else       m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
      end
      m_busy[i] = 1;
    end else begin
      m_busy[i] = 0;
    end
  endtask

  task automatic model_exp(input int i, output int b, output bit ea, output bit xa,
                           output bit ed, output bit xd);
    b  = (m_busy[i] == 2) ? (m_side_entry[i] ? 1 : 15) : 0;
    ea = (m_busy[i] == 1) && !m_deny[i] && m_side_entry[i];
    xa = (m_busy[i] == 1) && !m_deny[i] && !m_side_entry[i];
    ed = (m_busy[i] == 1) && m_deny[i] && m_de[i];
    xd = (m_busy[i] == 1) && m_deny[i] && m_dx[i];
  endtask

  initial begin
    int d, b;
    bit ea, xa, ed, xd;
    int cd_e [2];
    int cd_x [2];

    // ---- capacity 15: first entry, tie round-robin, reset in ADD_OUT, exit deny ----
    row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    entry_rows(0, 0, 0);
    entry_rows(0, 1, 0);
    entry_rows(0, 2, 0);
    row(0, 0, 1, 1, 0, 1, 3, 0,  0, 0, 0, 0, 0);
    row(0, 0, 1, 1, 0, 1, 3, 1,  0, 0, 0, 0, 0);
    row(0, 0, 1, 1, 0, 1, 4, 0,  1, 0, 0, 0, 0);
    exit_rows(0, 4, 0);
    row(0, 0, 1, 1, 0, 1, 3, 0,  0, 0, 0, 0, 0);
    row(0, 0, 1, 1, 0, 1, 3, 15, 0, 0, 0, 0, 0);
    row(0, 0, 1, 1, 0, 1, 2, 0,  0, 1, 0, 0, 0);
    entry_rows(0, 2, 0);
    entry_rows(0, 3, 0);
    entry_rows(0, 4, 0);
    row(0, 0, 0, 1, 0, 1, 5, 0,  0, 0, 0, 0, 0);
    row(0, 1, 0, 1, 0, 1, 5, 15, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    row(0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);

    // ---- capacity 4: adder fault at count 2, fill, entry deny, exit, reset clears err ----
    row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    entry_rows(1, 0, 0);
    entry_rows(1, 1, 0);
    row(1, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1);
    entry_rows(1, 2, 1);
    entry_rows(1, 3, 1);
    row(1, 0, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1);
    row(1, 0, 1, 0, 0, 1, 4, 0, 0, 0, 1, 0, 1);
    row(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1);
    exit_rows(1, 4, 1);
    row(1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (tv[k]) begin
      @(negedge clk);
      d = tv[k].d;
      rst[d]  = tv[k].rst;
      ereq[d] = tv[k].e;
      xreq[d] = tv[k].x;
      fc[d]   = tv[k].fc;
      #1;
      if (tv[k].chk)
        check_outputs(d, tv[k].cnt, tv[k].b, tv[k].ea, tv[k].xa, tv[k].ed, tv[k].xd, tv[k].er);
    end

    // ---- randomized traffic on both instances ----
    @(negedge clk);
    rst = 2'b11; ereq = '0; xreq = '0; fc = '0;
    cd_e = '{0, 0};
    cd_x = '{0, 0};
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_exp(i, b, ea, xa, ed, xd);
        check_outputs(i, m_cnt[i], b, ea, xa, ed, xd, m_err[i]);
        if (ea || ed) begin
          ereq[i] = 1'b0; cd_e[i] = 2;
        end else if (cd_e[i] > 0) begin
          cd_e[i]--;
        end else if (!ereq[i] && ($urandom_range(2) == 0)) begin
          ereq[i] = 1'b1;
        end
        if (xa || xd) begin
          xreq[i] = 1'b0; cd_x[i] = 2;
        end else if (cd_x[i] > 0) begin
          cd_x[i]--;
        end else if (!xreq[i] && ($urandom_range(2) == 0)) begin
          xreq[i] = 1'b1;
        end
        rst[i] = ($urandom_range(149) == 0);
        fc[i]  = ($urandom_range(39) == 0);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
